dtree_feature_feeder: RTL and testbench

Hardware front end for the dtree classifier. Accepts a stream of spike-feature samples from upstream and buffers one vector of FEATURES samples. Replays that vector into dtree, index 0..FEATURES-1 and wrapping, for as many passes as the tree requests. Captures the tree's level/path result into a held output register with its own valid/ready handshake, then loads the next vector.

---
 rtl/dtree_pkg.sv | 21 ++
 rtl/dtree_feature_buf.sv | 33 +++
 rtl/dtree_feature_feeder.sv | 135 +++++++++++++
 tb/tb_dtree_feature_feeder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared definitions for the dtree feature feeder: FSM encoding, default widths
// and helpers that size the index and pass counters.
package dtree_pkg;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    localparam int DEF_IN_WIDTH    = 10;
    localparam int DEF_LEVEL_WIDTH = 2;
    localparam int DEF_PATH_WIDTH  = 2;

    // A single-entry vector still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int pass_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dtree_feature_buf.sv
// Feature-vector register file: one write port, one read port, with a
// write-to-read bypass so a just-written sample can be read on the same edge.
module dtree_feature_buf
    import dtree_pkg::*;
#(
    parameter int FEATURES = 3,
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int IDX_W    = idx_width(FEATURES)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [IN_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [IN_WIDTH-1:0] rd_data
);

    logic [IN_WIDTH-1:0] mem [FEATURES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = mem[rd_idx];
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/dtree_feature_feeder.sv
// Front end for the dtree classifier: buffers one feature vector, replays it
// into the tree until a result appears (or passes run out), and holds the result.
module dtree_feature_feeder
    import dtree_pkg::*;
#(
    parameter int FEATURES    = 3,
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int LEVEL_WIDTH = DEF_LEVEL_WIDTH,
    parameter int PATH_WIDTH  = DEF_PATH_WIDTH,
    parameter int MAX_PASSES  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [IN_WIDTH-1:0]    in_sample,
    output logic                   in_ready,
    input  logic                   tree_ready,
    output logic                   tree_valid,
    output logic [IN_WIDTH-1:0]    tree_sample,
    input  logic [LEVEL_WIDTH-1:0] tree_level,
    input  logic [PATH_WIDTH-1:0]  tree_path,
    input  logic                   tree_out_valid,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [LEVEL_WIDTH-1:0] res_level,
    output logic [PATH_WIDTH-1:0]  res_path,
    output logic                   overrun,
    output logic                   timeout
);

    localparam int IDX_W = idx_width(FEATURES);
    localparam int PW    = pass_width(MAX_PASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURES - 1);

    logic [0:0]          state;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic [PW-1:0]       pass_cnt;

    logic                hs_in, last_in, hs_tree, cap, wrap, exhaust;
    logic [IDX_W-1:0]    next_rd, rd_addr;
    logic [PW-1:0]       pass_next;
    logic [IN_WIDTH-1:0] rd_data;

    assign hs_in     = (state == ST_FILL) && in_valid && in_ready;
    assign last_in   = hs_in && (wr_idx == LAST_IDX);
    assign hs_tree   = (state == ST_SERVE) && tree_valid && tree_ready;
    assign cap       = (state == ST_SERVE) && tree_out_valid;
    assign wrap      = (rd_idx == LAST_IDX);
    assign next_rd   = wrap ? '0 : rd_idx + IDX_W'(1);
    assign pass_next = pass_cnt + PW'(1);
    assign exhaust   = hs_tree && wrap && (pass_next == PW'(MAX_PASSES));
    // The fill-complete edge preloads entry 0; serving preloads the next entry.
    assign rd_addr   = (state == ST_SERVE) ? next_rd : '0;

    dtree_feature_buf #(
        .FEATURES (FEATURES),
        .IN_WIDTH (IN_WIDTH),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (hs_in),
        .wr_idx  (wr_idx),
        .wr_data (in_sample),
        .rd_idx  (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FILL;
            wr_idx      <= '0;
            rd_idx      <= '0;
            pass_cnt    <= '0;
            in_ready    <= 1'b0;
            tree_valid  <= 1'b0;
            tree_sample <= '0;
            res_valid   <= 1'b0;
            res_level   <= '0;
            res_path    <= '0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                ST_FILL: begin
                    in_ready <= !last_in;
                    if (hs_in) begin
                        wr_idx <= last_in ? '0 : wr_idx + IDX_W'(1);
                    end
                    if (last_in) begin
                        tree_valid  <= 1'b1;
                        tree_sample <= rd_data;
                        rd_idx      <= '0;
                        pass_cnt    <= '0;
                        state       <= ST_SERVE;
                    end
                end
                default: begin
                    // A result wins over a coincident handshake or pass exhaustion.
                    if (cap) begin
                        res_level  <= tree_level;
                        res_path   <= tree_path;
                        res_valid  <= 1'b1;
                        overrun    <= overrun | (res_valid && !res_ready);
                        tree_valid <= 1'b0;
                        in_ready   <= 1'b1;
                        wr_idx     <= '0;
                        rd_idx     <= '0;
                        pass_cnt   <= '0;
                        state      <= ST_FILL;
                    end else if (hs_tree) begin
                        rd_idx      <= next_rd;
                        tree_sample <= rd_data;
                        if (wrap) begin
                            pass_cnt <= pass_next;
                        end
                        if (exhaust) begin
                            timeout    <= 1'b1;
                            tree_valid <= 1'b0;
                            in_ready   <= 1'b1;
                            wr_idx     <= '0;
                            rd_idx     <= '0;
                            pass_cnt   <= '0;
                            state      <= ST_FILL;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtree_feature_feeder.sv
// Directed bench for dtree_feature_feeder with FEATURES=3, MAX_PASSES=4.
module tb_dtree_feature_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [9:0] in_sample = '0;
    logic       in_ready;
    logic       tree_ready = 1'b0;
    logic       tree_valid;
    logic [9:0] tree_sample;
    logic [1:0] tree_level = '0;
    logic [1:0] tree_path = '0;
    logic       tree_out_valid = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [1:0] res_level;
    logic [1:0] res_path;
    logic       overrun;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    dtree_feature_feeder #(
        .FEATURES(3), .IN_WIDTH(10), .LEVEL_WIDTH(2), .PATH_WIDTH(2), .MAX_PASSES(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
        .tree_ready(tree_ready), .tree_valid(tree_valid), .tree_sample(tree_sample),
        .tree_level(tree_level), .tree_path(tree_path), .tree_out_valid(tree_out_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_level(res_level),
        .res_path(res_path), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] v [3];
        v[0] = a; v[1] = b; v[2] = c;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_in_ready_before got %b want 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_sample = v[i];
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (tree_valid !== 1'b1 || tree_sample !== a || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_done got tv=%b ts=%0d ir=%b want tv=1 ts=%0d ir=0",
                     tree_valid, tree_sample, in_ready, a);
        end
    endtask

    task automatic serve(input int n, input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] v [3];
        v[0] = a; v[1] = b; v[2] = c;
        for (int k = 0; k < n; k++) begin
            vectors++;
            if (tree_sample !== v[k % 3] || tree_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL serve_hs%0d got ts=%0d tv=%b ir=%b want ts=%0d tv=1 ir=0",
                         k, tree_sample, tree_valid, in_ready, v[k % 3]);
            end
            tree_ready = 1'b1;
            step();
        end
        tree_ready = 1'b0;
    endtask

    task automatic capture(input logic [1:0] lvl, input logic [1:0] pth,
                           input logic tr, input logic rr);
        tree_out_valid = 1'b1;
        tree_level     = lvl;
        tree_path      = pth;
        tree_ready     = tr;
        res_ready      = rr;
        step();
        tree_out_valid = 1'b0;
        tree_ready     = 1'b0;
        res_ready      = 1'b0;
        vectors++;
        if (res_valid !== 1'b1 || res_level !== lvl || res_path !== pth ||
            tree_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL capture got rv=%b lvl=%0d pth=%0d tv=%b ir=%b want rv=1 lvl=%0d pth=%0d tv=0 ir=1",
                     res_valid, res_level, res_path, tree_valid, in_ready, lvl, pth);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({in_ready, tree_valid, tree_sample, res_valid, res_level, res_path, overrun, timeout} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got ir=%b tv=%b ts=%0d rv=%b ov=%b to=%b want all 0",
                     in_ready, tree_valid, tree_sample, res_valid, overrun, timeout);
        end
        step();
        reset = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ir got %b want 0", in_ready);
        end
        step();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_edge_ir got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        fill(10'd100, 10'd200, 10'd300);
        serve(3, 10'd100, 10'd200, 10'd300);
        capture(2'd2, 2'b10, 1'b1, 1'b0);
    endtask

    task automatic test_multi_pass();
        res_ready = 1'b1;
        fill(10'd100, 10'd200, 10'd300);
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_consumed got rv=%b want 0", res_valid);
        end
        serve(7, 10'd100, 10'd200, 10'd300);
        capture(2'd1, 2'b01, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        fill(10'd100, 10'd200, 10'd300);
        serve(11, 10'd100, 10'd200, 10'd300);
        vectors++;
        if (timeout !== 1'b0 || tree_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early got to=%b tv=%b want to=0 tv=1", timeout, tree_valid);
        end
        tree_ready = 1'b1;
        step();
        tree_ready = 1'b0;
        vectors++;
        if (timeout !== 1'b1 || tree_valid !== 1'b0 || in_ready !== 1'b1 ||
            res_valid !== 1'b1 || res_level !== 2'd1 || res_path !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_hit got to=%b tv=%b ir=%b rv=%b lvl=%0d want to=1 tv=0 ir=1 rv=1 lvl=1",
                     timeout, tree_valid, in_ready, res_valid, res_level);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] v [4];
        v[0] = 10'd5; v[1] = 10'd6; v[2] = 10'd7; v[3] = 10'd5;
        fill(10'd5, 10'd6, 10'd7);
        for (int k = 0; k < 3; k++) begin
            tree_ready = 1'b0;
            step();
            vectors++;
            if (tree_sample !== v[k]) begin
                miscompares++;
                $display("FAIL stall_hold%0d got %0d want %0d", k, tree_sample, v[k]);
            end
            tree_ready = 1'b1;
            step();
            vectors++;
            if (tree_sample !== v[k+1]) begin
                miscompares++;
                $display("FAIL stall_adv%0d got %0d want %0d", k, tree_sample, v[k+1]);
            end
        end
        tree_ready = 1'b0;
        capture(2'd0, 2'b01, 1'b0, 1'b1);
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL read_same_edge_overrun got %b want 0", overrun);
        end
    endtask

    task automatic test_overrun();
        fill(10'd5, 10'd6, 10'd7);
        serve(2, 10'd5, 10'd6, 10'd7);
        capture(2'd3, 2'b11, 1'b0, 1'b0);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set got %b want 1", overrun);
        end
    endtask

    task automatic test_async_reset();
        fill(10'd100, 10'd200, 10'd300);
        serve(2, 10'd100, 10'd200, 10'd300);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({in_ready, tree_valid, tree_sample, res_valid, res_level, res_path, overrun, timeout} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got ir=%b tv=%b ts=%0d rv=%b ov=%b to=%b want all 0",
                     in_ready, tree_valid, tree_sample, res_valid, overrun, timeout);
        end
        step();
        reset = 1'b0;
        step();
        vectors++;
        if (in_ready !== 1'b1 || tree_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset got ir=%b tv=%b want ir=1 tv=0", in_ready, tree_valid);
        end
        fill(10'd1, 10'd2, 10'd3);
        serve(3, 10'd1, 10'd2, 10'd3);
        capture(2'd2, 2'b11, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_pass();
        test_timeout();
        test_backpressure();
        test_overrun();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
